// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default payload width,
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Bit counter width; kept at least 1 so a 1-bit payload still has a counter.
  function automatic int cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Parity of a payload word: XOR-reduction, inverted when odd parity is selected.
module parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  odd,
  output logic                  parity
);

  assign parity = (^data) ^ odd;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one frame bit per CLK cycle, start / data LSB-first /
// optional parity / stop. TX_OUT and Busy come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy,
  output uart_state_e           dbg_state
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  parity_bit;

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data  (data_q),
    .odd   (par_typ_q),
    .parity(parity_bit)
  );

  // State register, together with the counter, latched frame and output flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next state; the frame fields are only captured on acceptance in IDLE.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d   = START;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the flops present the
  // bit of the state being entered, keeping start-bit latency at one edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_cnt_d];
      PARITY:  tx_d = parity_bit;
      STOP:    tx_d = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign TX_OUT    = tx_q;
  assign Busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of payload bits per frame.

Interface
REQ-002 The block SHALL have input CLK, width 1: the TX bit clock; one frame bit is sent per CLK cycle.
REQ-003 The block SHALL have input RST, width 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have input P_DATA, width DATA_WIDTH: the parallel payload.
REQ-005 The block SHALL have input Data_Valid, width 1: payload-present strobe.
REQ-006 The block SHALL have input PAR_EN, width 1: 1 appends a parity bit.
REQ-007 The block SHALL have input PAR_TYP, width 1: 0 selects even parity, 1 selects odd parity.
REQ-008 The block SHALL have output TX_OUT, width 1: the serial line, idle high.
REQ-009 The block SHALL have output Busy, width 1: high while a frame is in progress.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE, TX_OUT SHALL be 1 and Busy SHALL be 0.
REQ-012 A frame SHALL be accepted only when Data_Valid=1 is sampled in IDLE; at that edge P_DATA, PAR_EN and PAR_TYP SHALL be latched internally.
REQ-013 Data_Valid in any non-IDLE state SHALL be ignored; the latched values SHALL NOT change until the next acceptance.
REQ-014 At the edge after acceptance, the FSM SHALL enter START, TX_OUT SHALL go to 0 and Busy SHALL go to 1, giving a latency of one cycle from Data_Valid sampled to the start bit.
REQ-015 DATA SHALL last DATA_WIDTH cycles and send the latched bits LSB first; a bit counter of width clog2(DATA_WIDTH) SHALL run 0..DATA_WIDTH-1 and clear on leaving DATA.
REQ-016 After the last data bit, the FSM SHALL go to PARITY if the latched PAR_EN=1, else go directly to STOP.
REQ-017 In PARITY, TX_OUT SHALL be the XOR-reduction of the latched data; for odd parity (latched PAR_TYP=1) that value SHALL be inverted.
REQ-018 In STOP, TX_OUT SHALL be 1 for one cycle, then the FSM SHALL return to IDLE with Busy=0 at the next edge.
REQ-019 Busy SHALL stay high for exactly DATA_WIDTH+2 cycles (no parity) or DATA_WIDTH+3 cycles (parity).
REQ-020 Back-to-back frames SHALL be separated by at least one IDLE cycle with TX_OUT=1.
REQ-021 TX_OUT and Busy SHALL be registered outputs with no combinational path from the inputs.
REQ-022 Changes to P_DATA, PAR_EN or PAR_TYP during a frame SHALL NOT affect the frame in progress.

Reset
REQ-023 On RST=0, regardless of CLK, the block SHALL set state=IDLE, TX_OUT=1, Busy=0, and clear the bit counter and latched data.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no partial bits resumed after release.
REQ-025 After RST is released, the block SHALL accept Data_Valid at the first CLK edge.

Structure
REQ-026 The state encoding and the DATA_WIDTH default SHALL live in a shared package uart_pkg, which the receiver side also uses.
REQ-027 The parity computation SHALL be a sub-module parity_calc, parameterised by DATA_WIDTH.
REQ-028 The FSM, counter and output mux SHALL reside in uart_tx.

Verification
REQ-029 The bench SHALL cover: P_DATA=0xA5, PAR_EN=0, Data_Valid for 1 cycle -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 and Busy high for 10 cycles.
REQ-030 The bench SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; with PAR_TYP=1 -> parity bit 1; Busy high for 11 cycles.
REQ-031 The bench SHALL cover: P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1; P_DATA changed to 0xFF mid-frame -> frame still carries 0x07.
REQ-032 The bench SHALL cover: Data_Valid held high continuously with 0x55 -> repeated 10-bit frames, each separated by exactly one idle cycle with TX_OUT=1.
REQ-033 The bench SHALL cover: RST pulsed low during the DATA state -> TX_OUT=1 and Busy=0 immediately; a new 0x3C frame after release is correct.
REQ-034 The bench SHALL cover: Data_Valid pulsed during the STOP state -> pulse ignored and no new frame starts.
